// File: rtl/table_wr_packer.sv
// Packs single table write requests into INPUT_RATE-wide bundles with idle/flush emission.
// Optional macro TABLE_WR_PACKER_MERGE_EN: merge duplicate indices in place instead of splitting bundles.
module table_wr_packer #(
  parameter int TABLE_SIZE    = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int INPUT_RATE    = 2,
  parameter int FLUSH_TIMEOUT = 4,
  localparam int IW = $clog2(TABLE_SIZE),
  localparam int CW = $clog2(INPUT_RATE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IW-1:0]                  in_index,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           flush,
  output logic                           wr_en,
  output logic [INPUT_RATE*IW-1:0]       index_wr,
  output logic [INPUT_RATE*DATA_WIDTH-1:0] data_wr,
  output logic [CW-1:0]                  pending_cnt
);

  typedef logic [INPUT_RATE-1:0][IW-1:0]         idx_vec_t;
  typedef logic [INPUT_RATE-1:0][DATA_WIDTH-1:0] dat_vec_t;

  idx_vec_t lane_idx, w_idx, nxt_idx, pad_idx, wr_idx_q;
  dat_vec_t lane_dat, w_dat, nxt_dat, pad_dat, wr_dat_q;
  logic [CW-1:0]         cnt, w_n, nxt_cnt;
  logic [7:0]            timer, nxt_timer;
  logic [INPUT_RATE-1:0] hit;
  logic                  acc, any_hit, emit;

  assign in_ready    = ~rst;
  assign acc         = in_valid & in_ready;
  assign pending_cnt = cnt;
  assign index_wr    = wr_idx_q;
  assign data_wr     = wr_dat_q;

  always_comb begin
    hit = '0;
    for (int j = 0; j < INPUT_RATE; j++)
      hit[j] = (j < int'(cnt)) && (lane_idx[j] == in_index);
  end
  assign any_hit = |hit;

  // w_* is the bundle as it stands after this cycle's accept; it is what gets emitted.
  always_comb begin
    w_idx     = lane_idx;
    w_dat     = lane_dat;
    w_n       = cnt;
    nxt_idx   = lane_idx;
    nxt_dat   = lane_dat;
    nxt_cnt   = cnt;
    nxt_timer = timer;
    emit      = 1'b0;
    if (acc) begin
      nxt_timer = '0;
      if (!any_hit) begin
        for (int j = 0; j < INPUT_RATE; j++)
          if (j == int'(cnt)) begin
            w_idx[j] = in_index;
            w_dat[j] = in_data;
          end
        w_n = cnt + CW'(1);
      end
`ifdef TABLE_WR_PACKER_MERGE_EN
      else begin
        for (int j = 0; j < INPUT_RATE; j++)
          if (hit[j]) w_dat[j] = in_data;
      end
      emit    = (w_n == CW'(INPUT_RATE)) || flush;
      nxt_idx = w_idx;
      nxt_dat = w_dat;
      nxt_cnt = emit ? '0 : w_n;
`else
      // A duplicate closes the held bundle; the new request starts the next one.
      emit = any_hit || (w_n == CW'(INPUT_RATE)) || flush;
      if (any_hit) begin
        nxt_idx[0] = in_index;
        nxt_dat[0] = in_data;
        nxt_cnt    = CW'(1);
      end else begin
        nxt_idx = w_idx;
        nxt_dat = w_dat;
        nxt_cnt = emit ? '0 : w_n;
      end
`endif
    end else if (cnt != '0) begin
      if (flush || ((timer + 8'd1) >= 8'(FLUSH_TIMEOUT))) begin
        emit      = 1'b1;
        nxt_cnt   = '0;
        nxt_timer = '0;
      end else begin
        nxt_timer = timer + 8'd1;
      end
    end
  end

  // Unused lanes repeat lane 0 so a partial bundle rewrites the same entry.
  always_comb begin
    for (int j = 0; j < INPUT_RATE; j++) begin
      pad_idx[j] = (j < int'(w_n)) ? w_idx[j] : w_idx[0];
      pad_dat[j] = (j < int'(w_n)) ? w_dat[j] : w_dat[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx <= '0;
      lane_dat <= '0;
      cnt      <= '0;
      timer    <= '0;
      wr_en    <= 1'b0;
      wr_idx_q <= '0;
      wr_dat_q <= '0;
    end else begin
      lane_idx <= nxt_idx;
      lane_dat <= nxt_dat;
      cnt      <= nxt_cnt;
      timer    <= nxt_timer;
      wr_en    <= emit;
      if (emit) begin
        wr_idx_q <= pad_idx;
        wr_dat_q <= pad_dat;
      end
    end
  end

endmodule

// File: tb/tb_table_wr_packer.sv
// Directed and random checks of table_wr_packer against a queue-based bundle model and a shadow table.
module tb_table_wr_packer;
  localparam int TS = 32, DW = 8, R = 2, TO = 4, IW = 5, CW = 2;

  logic clk = 1'b0;
  logic rst, in_valid, flush;
  logic [IW-1:0] in_index;
  logic [DW-1:0] in_data;
  logic in_ready, wr_en;
  logic [R*IW-1:0] index_wr;
  logic [R*DW-1:0] data_wr;
  logic [CW-1:0] pending_cnt;

  table_wr_packer #(.TABLE_SIZE(TS), .DATA_WIDTH(DW), .INPUT_RATE(R), .FLUSH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_data(in_data), .flush(flush), .wr_en(wr_en), .index_wr(index_wr), .data_wr(data_wr),
    .pending_cnt(pending_cnt));

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] i; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  int idle = 0;
  int n_chk = 0, n_fail = 0, n_wr = 0;
  logic m_wr = 1'b0;
  logic [R*IW-1:0] m_idx = '0;
  logic [R*DW-1:0] m_dat = '0;
  logic [DW-1:0] ref_tab [TS];
  logic [DW-1:0] dut_tab [TS];
  bit ref_set [TS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic void emit_q();
    m_wr = 1'b1;
    for (int j = 0; j < R; j++) begin
      if (j < q.size()) begin
        m_idx[j*IW +: IW] = q[j].i;
        m_dat[j*DW +: DW] = q[j].d;
      end else begin
        m_idx[j*IW +: IW] = q[0].i;
        m_dat[j*DW +: DW] = q[0].d;
      end
    end
    q.delete();
  endfunction

  task automatic step(input logic v, input logic [IW-1:0] i, input logic [DW-1:0] d, input logic f);
    int k;
    bit done;
    in_valid = v; in_index = i; in_data = d; flush = f;
    @(posedge clk);
    k = -1; done = 0; m_wr = 1'b0;
    if (rst) begin
      q.delete(); idle = 0; m_idx = '0; m_dat = '0;
    end else if (v) begin
      for (int j = 0; j < q.size(); j++) if (q[j].i == i) k = j;
      ref_tab[i] = d; ref_set[i] = 1; idle = 0;
      if (k >= 0) begin
`ifdef TABLE_WR_PACKER_MERGE_EN
        q[k].d = d;
`else
        emit_q(); done = 1;
`endif
      end
      if (k < 0 || done) q.push_back('{i, d});
      if (!done && (q.size() == R || f)) emit_q();
    end else if (q.size() > 0) begin
      idle++;
      if (f || idle >= TO) begin emit_q(); idle = 0; end
    end
    #1;
    if (wr_en === 1'b1) begin
      n_wr++;
      for (int j = 0; j < R; j++) dut_tab[index_wr[j*IW +: IW]] = data_wr[j*DW +: DW];
    end
    chk("wr_en", wr_en, m_wr);
    chk("index_wr", index_wr, m_idx);
    chk("data_wr", data_wr, m_dat);
    chk("pending_cnt", pending_cnt, q.size());
    chk("in_ready", in_ready, !rst);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_index = '0; in_data = '0; flush = 0;
    for (int t = 0; t < TS; t++) begin ref_tab[t] = '0; dut_tab[t] = '0; ref_set[t] = 0; end
    step(0, 0, 0, 0);
    step(1, 1, 8'h99, 1);
    rst = 1'b0;
    step(0, 0, 0, 0);

    // full bundle
    step(1, 3, 8'hAA, 0);
    step(1, 7, 8'h55, 0);
    chk("full_wr", wr_en, 1'b1);
    chk("full_idx", index_wr, {5'd7, 5'd3});
    chk("full_dat", data_wr, 16'h55AA);

    // idle timeout
    step(1, 9, 8'h11, 0);
    n_wr = 0;
    for (int t = 0; t < 4; t++) step(0, 0, 0, 0);
    chk("to_wr", wr_en, 1'b1);
    chk("to_idx", index_wr, {5'd9, 5'd9});
    chk("to_dat", data_wr, 16'h1111);
    for (int t = 0; t < 3; t++) step(0, 0, 0, 0);
    chk("to_once", n_wr, 1);

    // duplicate index
    n_wr = 0;
    step(1, 5, 8'h01, 0);
    step(1, 5, 8'h02, 0);
`ifndef TABLE_WR_PACKER_MERGE_EN
    chk("dup_split_idx", index_wr, {5'd5, 5'd5});
    chk("dup_split_dat", data_wr, 16'h0101);
`endif
    step(1, 6, 8'h03, 0);
    chk("dup_idx", index_wr, {5'd6, 5'd5});
    chk("dup_dat", data_wr, 16'h0302);
`ifdef TABLE_WR_PACKER_MERGE_EN
    chk("dup_count", n_wr, 1);
`else
    chk("dup_count", n_wr, 2);
`endif

    // flush with accept, then flush with nothing pending
    step(1, 2, 8'h22, 1);
    chk("fl_wr", wr_en, 1'b1);
    chk("fl_idx", index_wr, {5'd2, 5'd2});
    step(0, 0, 0, 1);
    chk("fl_empty", wr_en, 1'b0);

    // reset mid-bundle drops the entry
    step(1, 4, 8'h44, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    n_wr = 0;
    for (int t = 0; t < 10; t++) step(0, 0, 0, 0);
    chk("rst_drop", n_wr, 0);
    chk("rst_cnt", pending_cnt, 0);

    // random stream checked end to end through a shadow table
    for (int t = 0; t < TS; t++) begin ref_set[t] = 0; dut_tab[t] = '0; end
    for (int n = 0; n < 200; n++) begin
      logic [IW-1:0] ri;
      ri = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 3)) : IW'($urandom_range(0, TS-1));
      step($urandom_range(0, 9) < 7, ri, DW'($urandom), $urandom_range(0, 9) == 0);
    end
    step(0, 0, 0, 1);
    for (int t = 0; t < 6; t++) step(0, 0, 0, 0);
    for (int t = 0; t < TS; t++)
      if (ref_set[t]) chk("table", dut_tab[t], ref_tab[t]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
